pong_score_keeper: RTL

Tracks the score of both Pong players and presents each score as a 4-bit binary value that drives a per-player binary-to-7-segment decoder directly downstream. Point events come from the ball/paddle game logic as single-cycle pulses. A small state machine gates scoring, applies a hold-off after every accepted point, and detects the winning score, then freezes the display until the next game start.

---
 rtl/pong_score_keeper_if.sv | 21 ++
 rtl/pong_score_keeper.sv | 120 ++++++++++++
 2 files changed

// File: rtl/pong_score_keeper_if.sv
// Point-event and score-display signals between the game logic and the score keeper.
interface pong_score_keeper_if;
  logic       i_Game_Start;
  logic       i_Point_P1;
  logic       i_Point_P2;
  logic [3:0] o_P1_Score;
  logic [3:0] o_P2_Score;
  logic       o_Game_Active;
  logic       o_Game_Over;
  logic       o_Winner;

  modport master (
    output i_Game_Start, i_Point_P1, i_Point_P2,
    input  o_P1_Score, o_P2_Score, o_Game_Active, o_Game_Over, o_Winner
  );

  modport slave (
    input  i_Game_Start, i_Point_P1, i_Point_P2,
    output o_P1_Score, o_P2_Score, o_Game_Active, o_Game_Over, o_Winner
  );
endinterface

// File: rtl/pong_score_keeper.sv
// Pong score keeper: gates point pulses, applies a post-point hold-off and detects the winner.
//
//   state        | meaning
//   ST_IDLE      | no game yet, points ignored, scores 0
//   ST_RUNNING   | points accepted
//   ST_HOLDOFF   | points ignored while the hold-off counter runs down
//   ST_GAME_OVER | scores and winner frozen until the next game start
module pong_score_keeper #(
  parameter int WIN_SCORE      = 9,
  parameter int HOLDOFF_CYCLES = 25000000
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  pong_score_keeper_if.slave bus
);

  localparam int                CNT_W     = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [3:0]        WIN_VAL   = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUNNING,
    ST_HOLDOFF,
    ST_GAME_OVER
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       p1_score, p1_nxt, p1_inc;
  logic [3:0]       p2_score, p2_nxt, p2_inc;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             winner, winner_nxt;
  logic             active_q, over_q;

  assign p1_inc = p1_score + 4'd1;
  assign p2_inc = p2_score + 4'd1;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state    <= ST_IDLE;
      p1_score <= 4'd0;
      p2_score <= 4'd0;
      cnt      <= '0;
      winner   <= 1'b0;
      active_q <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      p1_score <= p1_nxt;
      p2_score <= p2_nxt;
      cnt      <= cnt_nxt;
      winner   <= winner_nxt;
      active_q <= (state_nxt == ST_RUNNING) || (state_nxt == ST_HOLDOFF);
      over_q   <= (state_nxt == ST_GAME_OVER);
    end
  end

  always_comb begin
    state_nxt  = state;
    p1_nxt     = p1_score;
    p2_nxt     = p2_score;
    cnt_nxt    = cnt;
    winner_nxt = winner;

    // A game start outranks any point arriving in the same cycle.
    if (bus.i_Game_Start) begin
      state_nxt  = ST_RUNNING;
      p1_nxt     = 4'd0;
      p2_nxt     = 4'd0;
      cnt_nxt    = '0;
      winner_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
        end
        ST_RUNNING: begin
          // Both points together is a double fault and is dropped entirely.
          if (bus.i_Point_P1 && !bus.i_Point_P2) begin
            p1_nxt = p1_inc;
            if (p1_inc == WIN_VAL) begin
              state_nxt  = ST_GAME_OVER;
              winner_nxt = 1'b0;
            end else begin
              state_nxt = ST_HOLDOFF;
              cnt_nxt   = HOLD_LOAD;
            end
          end else if (bus.i_Point_P2 && !bus.i_Point_P1) begin
            p2_nxt = p2_inc;
            if (p2_inc == WIN_VAL) begin
              state_nxt  = ST_GAME_OVER;
              winner_nxt = 1'b1;
            end else begin
              state_nxt = ST_HOLDOFF;
              cnt_nxt   = HOLD_LOAD;
            end
          end
        end
        ST_HOLDOFF: begin
          if (cnt == '0) begin
            state_nxt = ST_RUNNING;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        ST_GAME_OVER: begin
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_P1_Score    = p1_score;
  assign bus.o_P2_Score    = p2_score;
  assign bus.o_Game_Active = active_q;
  assign bus.o_Game_Over   = over_q;
  assign bus.o_Winner      = winner;

endmodule
